div_operand_queue: RTL and testbench

DIV_OPERAND_QUEUE -- requirements
Module: div_operand_queue

---
 rtl/div_pkg.sv | 17 +
 rtl/div_fifo.sv | 66 ++++++
 rtl/div_operand_queue.sv | 124 ++++++++++++
 tb/tb_div_operand_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the divider operand queue.
// Entries are sized to DIV_MAX_W; instances keep only their low M/N bits.
// quot_w() gives the quotient width M-N+1 used on the divider ports.
package div_pkg;

  localparam int DIV_MAX_W = 32;

  typedef struct packed {
    logic [DIV_MAX_W-1:0] dividend;
    logic [DIV_MAX_W-1:0] divisor;
  } div_entry_t;

  function automatic int quot_w(input int m, input int n);
    return m - n + 1;
  endfunction

endpackage

// File: rtl/div_fifo.sv
// Operand storage: DEPTH-entry circular buffer of div_entry_t.
// Head is visible combinationally; push/pop take effect on the rising edge.
// Backpressure: full blocks push, empty blocks pop; head reads zero when empty.
module div_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  div_entry_t push_dat,
  input  logic       pop,
  output div_entry_t head_dat,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;
  div_entry_t    mem_q [DEPTH];

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next pointer/count; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/div_operand_queue.sv
// Operand queue in front of a combinational divider; result held in one output register.
// Latency: one cycle minimum from push edge to out_valid; one result per cycle sustained.
// Backpressure: in_ready = FIFO not full; head pops only when the result register is free or draining.
// Optional macro DIV_ZERO_CHECK_EN: flag zero divisors (out_dz=1, quotient all-ones, out_ovf=0).
module div_operand_queue
  import div_pkg::*;
#(
  parameter int M     = 5,
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [M-1:0]             in_dividend,
  input  logic [N-1:0]             in_divisor,
  output logic [M-1:0]             div_dividend,
  output logic [N-1:0]             div_divisor,
  input  logic [quot_w(M,N)-1:0]   div_quotient,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [quot_w(M,N)-1:0]   out_quotient,
  output logic                     out_ovf,
  output logic                     out_dz
);

  localparam int QW = quot_w(M, N);

  div_entry_t     push_dat, head_dat;
  logic           fifo_empty, fifo_full;
  logic           push, pop;
  logic           unused_head;

  logic [M:0]     dvd_ext, dvs_sh;
  logic           ovf_raw, res_ovf, res_dz;
  logic [QW-1:0]  res_quot;

  logic           out_valid_q, out_valid_d;
  logic [QW-1:0]  out_quotient_q, out_quotient_d;
  logic           out_ovf_q, out_ovf_d;
  logic           out_dz_q, out_dz_d;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && (!out_valid_q || out_ready);

  assign push_dat.dividend = DIV_MAX_W'(in_dividend);
  assign push_dat.divisor  = DIV_MAX_W'(in_divisor);

  div_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Head is already zero when empty, so the divider sees zeros then
  assign div_dividend = head_dat.dividend[M-1:0];
  assign div_divisor  = head_dat.divisor[N-1:0];
  // Upper entry bits are always zero for this instance
  assign unused_head  = ^{head_dat.dividend >> M, head_dat.divisor >> N};

  // Overflow: quotient needs more than QW bits when dividend >= divisor * 2^QW
  always_comb begin
    dvd_ext = {1'b0, div_dividend};
    dvs_sh  = (M+1)'(div_divisor) << QW;
    ovf_raw = (dvd_ext >= dvs_sh);
  end

  // Result shaping, with optional zero-divisor override
  always_comb begin
`ifdef DIV_ZERO_CHECK_EN
    res_dz   = (div_divisor == '0);
    res_quot = res_dz ? '1 : div_quotient;
    res_ovf  = res_dz ? 1'b0 : ovf_raw;
`else
    res_dz   = 1'b0;
    res_quot = div_quotient;
    res_ovf  = ovf_raw;
`endif
  end

  // Result register: load on pop, clear on drain without refill, else hold
  always_comb begin
    out_valid_d    = out_valid_q;
    out_quotient_d = out_quotient_q;
    out_ovf_d      = out_ovf_q;
    out_dz_d       = out_dz_q;
    if (pop) begin
      out_valid_d    = 1'b1;
      out_quotient_d = res_quot;
      out_ovf_d      = res_ovf;
      out_dz_d       = res_dz;
    end else if (out_ready) begin
      out_valid_d    = 1'b0;
    end
  end

  // Result register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_quotient_q <= '0;
      out_ovf_q      <= 1'b0;
      out_dz_q       <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_quotient_q <= out_quotient_d;
      out_ovf_q      <= out_ovf_d;
      out_dz_q       <= out_dz_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_quotient = out_quotient_q;
  assign out_ovf      = out_ovf_q;
  assign out_dz       = out_dz_q;

endmodule

// File: tb/tb_div_operand_queue.sv
// Scoreboard bench for div_operand_queue (M=5, N=3, DEPTH=4).
// Stimulus drives #1 after posedge and queues expected results on acceptance.
// Monitor samples on negedge and checks each transfer plus hold stability.
module tb_div_operand_queue;

  localparam int M  = 5;
  localparam int N  = 3;
  localparam int QW = 3;

  typedef struct {
    logic [QW-1:0] q;
    logic          ovf;
    logic          dz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_dividend;
  logic [N-1:0]  in_divisor;
  logic [M-1:0]  div_dividend;
  logic [N-1:0]  div_divisor;
  logic [QW-1:0] div_quotient;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_quotient;
  logic          out_ovf;
  logic          out_dz;

  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;
  exp_t sb[$];

  logic          hold_vld = 1'b0;
  logic [QW-1:0] hold_q;
  logic          hold_ovf, hold_dz;

  always #5 clk = ~clk;

  div_operand_queue #(.M(M), .N(N), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_ovf      (out_ovf),
    .out_dz       (out_dz)
  );

  // External combinational divider; returns 0 for a zero divisor
  always_comb begin
    div_quotient = '0;
    if (div_divisor != '0) div_quotient = QW'(div_dividend / {2'b00, div_divisor});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every transfer against the scoreboard, and held outputs for stability
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && out_valid) begin
        chk("hold_quotient", 32'(out_quotient), 32'(hold_q));
        chk("hold_ovf", 32'(out_ovf), 32'(hold_ovf));
        chk("hold_dz", 32'(out_dz), 32'(hold_dz));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(out_quotient), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", 32'(out_quotient), 32'(e.q));
          chk("ovf", 32'(out_ovf), 32'(e.ovf));
          chk("dz", 32'(out_dz), 32'(e.dz));
        end
      end
      hold_vld = out_valid && !out_ready;
      hold_q   = out_quotient;
      hold_ovf = out_ovf;
      hold_dz  = out_dz;
    end
  end

  // Offer one pair; on acceptance queue its expected result and consume the edge
  task automatic push(input logic [M-1:0] dvd, input logic [N-1:0] dvs,
                      input logic [QW-1:0] q, input logic ovf, input logic dz);
    int   n;
    exp_t e;
    in_valid    = 1'b1;
    in_dividend = dvd;
    in_divisor  = dvs;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.q = q; e.ovf = ovf; e.dz = dz;
      sb.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  logic [M-1:0]  cv_dvd [8] = '{5'd20, 5'd17, 5'd9, 5'd30, 5'd14, 5'd1, 5'd22, 5'd8};
  logic [N-1:0]  cv_dvs [8] = '{3'd3,  3'd5,  3'd4, 3'd7,  3'd2,  3'd1, 3'd6,  3'd5};
  logic [QW-1:0] cv_q   [8] = '{3'd6,  3'd3,  3'd2, 3'd4,  3'd7,  3'd1, 3'd3,  3'd1};
  logic [M-1:0]  bp_dvd [5] = '{5'd10, 5'd12, 5'd6, 5'd4, 5'd3};
  logic [N-1:0]  bp_dvs [5] = '{3'd2,  3'd3,  3'd2, 3'd2, 3'd3};
  logic [QW-1:0] bp_q   [5] = '{3'd5,  3'd4,  3'd3, 3'd2, 3'd1};

  initial begin
    int n0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(out_quotient), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_dz", 32'(out_dz), 32'd0);
    chk("rst_count", 32'(dut.u_fifo.count_q), 32'd0);
    chk("rst_div_dividend", 32'(div_dividend), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Single pair 13/3: visible one edge after the push edge
    push(5'd13, 3'd3, 3'd4, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_quotient", 32'(out_quotient), 32'd4);
    wait_drain();

    // Overflow boundary: 31/1 overflows, 7/1 just fits
    push(5'd31, 3'd1, 3'd7, 1'b1, 1'b0);
    push(5'd7,  3'd1, 3'd7, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: five pushes with out_ready low fill result register + FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(bp_dvd[i], bp_dvs[i], bp_q[i], 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("bp_count_full", 32'(dut.u_fifo.count_q), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_result", 32'(out_quotient), 32'd5);
    in_valid    = 1'b1;
    in_dividend = 5'd15;
    in_divisor  = 3'd5;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_held_count", 32'(dut.u_fifo.count_q), 32'd4);
      chk("bp_held_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Streaming: one result per cycle, occupancy constant at one
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      if (i >= 1) chk("stream_count", 32'(dut.u_fifo.count_q), 32'd1);
      if (i >= 2) chk("stream_out_valid", 32'(out_valid), 32'd1);
      push(cv_dvd[i], cv_dvs[i], cv_q[i], 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    wait_drain();
    chk("stream_results", 32'(n_out - n0), 32'd8);

    // Zero divisor
`ifdef DIV_ZERO_CHECK_EN
    push(5'd9, 3'd0, 3'b111, 1'b0, 1'b1);
`else
    push(5'd9, 3'd0, 3'b000, 1'b1, 1'b0);
`endif
    in_valid = 1'b0;
    wait_drain();

    // Reset with three entries queued and one result held
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(bp_dvd[i], bp_dvs[i], bp_q[i], 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(dut.u_fifo.count_q), 32'd3);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(dut.u_fifo.count_q), 32'd0);
    chk("mid_rst_quotient", 32'(out_quotient), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    push(5'd13, 3'd3, 3'd4, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
